// File: rtl/axis_sum_pkg.sv
// Shared types and default parameters for the AXI-Stream frame accumulator.
// Imported by the lane-sum sub-module, the top level and the testbench.
package axis_sum_pkg;

    typedef enum logic {
        SUM_WORD = 1'b0,
        SUM_BYTE = 1'b1
    } sum_mode_e;

    localparam int          DEF_DATA_W   = 32;
    localparam int          DEF_SUM_W    = 32;
    localparam int          DEF_CNT_W    = 32;
    localparam logic [31:0] DEF_ACCEL_ID = 32'hdeadbeef;

    localparam int REC_SUM_W = DEF_SUM_W;
    localparam int REC_CNT_W = DEF_CNT_W;

    // Result record at the default widths; the top builds its own at its parameter widths.
    typedef struct packed {
        logic [REC_SUM_W-1:0] sum;
        logic [REC_CNT_W-1:0] cnt;
        logic                 ovf;
    } frame_rec_t;

endpackage

// File: rtl/axis_keep_lane_sum.sv
// Combinational beat term: applies the byte mask, then returns either the
// masked word or the sum of its masked bytes, zero-extended to SUM_W.
module axis_keep_lane_sum
    import axis_sum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SUM_W  = DEF_SUM_W
) (
    input  logic [DATA_W-1:0]   data_i,
    input  logic [DATA_W/8-1:0] keep_i,
    input  logic                mode_i,
    output logic [SUM_W-1:0]    term_o
);

    localparam int KEEP_W = DATA_W / 8;
    // Wide enough to hold KEEP_W bytes of 0xFF without wrapping.
    localparam int LANE_W = 8 + $clog2(KEEP_W);

    logic [DATA_W-1:0] maskedWord;
    logic [LANE_W-1:0] laneSum;

    always_comb begin
        maskedWord = '0;
        laneSum    = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            maskedWord[i*8 +: 8] = keep_i[i] ? data_i[i*8 +: 8] : 8'h00;
            laneSum = laneSum + LANE_W'(maskedWord[i*8 +: 8]);
        end
    end

    assign term_o = (mode_i == SUM_BYTE) ? SUM_W'(laneSum) : SUM_W'(maskedWord);

endmodule

// File: rtl/axis_frame_sum.sv
// AXI-Stream frame accumulator: sums byte-masked beats per TLAST-delimited
// frame and presents one registered result record per frame.
module axis_frame_sum
    import axis_sum_pkg::*;
#(
    parameter int          DATA_W   = DEF_DATA_W,
    parameter int          SUM_W    = DEF_SUM_W,
    parameter int          CNT_W    = DEF_CNT_W,
    parameter logic [31:0] ACCEL_ID = DEF_ACCEL_ID
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                sum_mode,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    input  logic [DATA_W/8-1:0] s_keep,
    input  logic                s_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [SUM_W-1:0]    m_sum,
    output logic [CNT_W-1:0]    m_cnt,
    output logic                m_ovf,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic [31:0]         accel_id
);

    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } result_t;

    logic [SUM_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    result_t          rec_q, rec_d;
    logic             mValid_q, mValid_d;
    logic [CNT_W-1:0] frameCnt_q, frameCnt_d;

    logic [SUM_W-1:0] beatTerm;
    logic [SUM_W:0]   sumExt;
    logic [CNT_W-1:0] cntNext;
    logic             ovfNext;
    logic             beatAccept;

    axis_keep_lane_sum #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W)
    ) u_lane_sum (
        .data_i (s_data),
        .keep_i (s_keep),
        .mode_i (sum_mode),
        .term_o (beatTerm)
    );

    // One-entry result buffer: input stalls whenever a record is pending and not taken.
    assign s_ready    = !mValid_q | m_ready;
    assign beatAccept = s_valid & s_ready;

    assign sumExt  = {1'b0, acc_q} + {1'b0, beatTerm};
    assign ovfNext = ovf_q | sumExt[SUM_W];
    assign cntNext = cnt_q + CNT_W'(|s_keep);

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        rec_d      = rec_q;
        mValid_d   = mValid_q;
        frameCnt_d = frameCnt_q;

        if (mValid_q && m_ready) begin
            mValid_d = 1'b0;
        end

        // Clear wins over the beat, so an accepted beat in a clear cycle is dropped.
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (beatAccept) begin
            if (s_last) begin
                rec_d      = '{sum: sumExt[SUM_W-1:0], cnt: cntNext, ovf: ovfNext};
                mValid_d   = 1'b1;
                frameCnt_d = frameCnt_q + 1'b1;
                acc_d      = '0;
                cnt_d      = '0;
                ovf_d      = 1'b0;
            end else begin
                acc_d = sumExt[SUM_W-1:0];
                cnt_d = cntNext;
                ovf_d = ovfNext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            rec_q      <= '0;
            mValid_q   <= 1'b0;
            frameCnt_q <= '0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            rec_q      <= rec_d;
            mValid_q   <= mValid_d;
            frameCnt_q <= frameCnt_d;
        end
    end

    assign m_valid   = mValid_q;
    assign m_sum     = rec_q.sum;
    assign m_cnt     = rec_q.cnt;
    assign m_ovf     = rec_q.ovf;
    assign frame_cnt = frameCnt_q;
    assign accel_id  = ACCEL_ID;

endmodule

// File: tb/tb_axis_frame_sum.sv
// Directed self-checking bench for axis_frame_sum at default parameters,
// with hand-computed expected records.
module tb_axis_frame_sum;
    import axis_sum_pkg::*;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        sum_mode;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_sum;
    logic [31:0] m_cnt;
    logic        m_ovf;
    logic [31:0] frame_cnt;
    logic [31:0] accel_id;

    int checks = 0;
    int errors = 0;

    axis_frame_sum dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .sum_mode  (sum_mode),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_keep    (s_keep),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_sum     (m_sum),
        .m_cnt     (m_cnt),
        .m_ovf     (m_ovf),
        .frame_cnt (frame_cnt),
        .accel_id  (accel_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the edge happen, then settle 1 ns past it.
    task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic [3:0] keep,
                                 input logic last, input logic mode, input logic rdy, input logic clr);
        s_valid  = valid;
        s_data   = data;
        s_keep   = keep;
        s_last   = last;
        sum_mode = mode;
        m_ready  = rdy;
        clear    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkRecord(input string tag, input logic [31:0] sum, input logic [31:0] cnt,
                               input logic ovf, input logic [31:0] frames);
        frame_rec_t expRec;
        frame_rec_t obsRec;
        expRec = '{sum: sum, cnt: cnt, ovf: ovf};
        obsRec = '{sum: m_sum, cnt: m_cnt, ovf: m_ovf};
        checkOutput({tag, "_valid"}, 80'(m_valid), 80'(1'b1));
        checkOutput({tag, "_rec"}, 80'(obsRec), 80'(expRec));
        checkOutput({tag, "_frames"}, 80'(frame_cnt), 80'(frames));
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, SUM_WORD, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        clear    = 1'b0;
        sum_mode = SUM_WORD;
        s_valid  = 1'b0;
        s_data   = '0;
        s_keep   = '0;
        s_last   = 1'b0;
        m_ready  = 1'b0;
        doReset();
        doReset();

        checkOutput("rst_valid", 80'(m_valid), 80'(1'b0));
        checkOutput("rst_ready", 80'(s_ready), 80'(1'b1));
        checkOutput("rst_rec", 80'({m_sum, m_cnt, m_ovf}), 80'(0));
        checkOutput("rst_frames", 80'(frame_cnt), 80'(0));
        checkOutput("accel_id", 80'(accel_id), 80'(32'hdeadbeef));

        // Three-beat word-mode frame.
        applyStimulus(1'b1, 32'h1, 4'hF, 1'b0, SUM_WORD, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h2, 4'hF, 1'b0, SUM_WORD, 1'b1, 1'b0);
        checkOutput("mid_frame_valid", 80'(m_valid), 80'(1'b0));
        applyStimulus(1'b1, 32'h3, 4'hF, 1'b1, SUM_WORD, 1'b1, 1'b0);
        checkRecord("word3", 32'd6, 32'd3, 1'b0, 32'd1);

        // Keep masking, back-to-back single-beat frames in both modes.
        applyStimulus(1'b1, 32'hAABBCCDD, 4'h5, 1'b1, SUM_WORD, 1'b1, 1'b0);
        checkRecord("keep_word", 32'h00BB00DD, 32'd1, 1'b0, 32'd2);
        applyStimulus(1'b1, 32'hAABBCCDD, 4'h5, 1'b1, SUM_BYTE, 1'b1, 1'b0);
        checkRecord("keep_byte", 32'h198, 32'd1, 1'b0, 32'd3);

        // Overflow, then a clean frame showing the sticky flag was reset.
        applyStimulus(1'b1, 32'hFFFFFFFF, 4'hF, 1'b0, SUM_WORD, 1'b1, 1'b0);
        checkOutput("retire_valid", 80'(m_valid), 80'(1'b0));
        applyStimulus(1'b1, 32'h2, 4'hF, 1'b1, SUM_WORD, 1'b1, 1'b0);
        checkRecord("ovf", 32'd1, 32'd2, 1'b1, 32'd4);
        applyStimulus(1'b1, 32'h5, 4'hF, 1'b1, SUM_WORD, 1'b1, 1'b0);
        checkRecord("after_ovf", 32'd5, 32'd1, 1'b0, 32'd5);

        // Backpressure: frame A={7} then hold m_ready low.
        applyStimulus(1'b1, 32'h7, 4'hF, 1'b1, SUM_WORD, 1'b1, 1'b0);
        checkRecord("bp_a", 32'd7, 32'd1, 1'b0, 32'd6);
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, SUM_WORD, 1'b0, 1'b0);
        checkOutput("bp_s_ready", 80'(s_ready), 80'(1'b0));
        checkRecord("bp_hold1", 32'd7, 32'd1, 1'b0, 32'd6);
        applyStimulus(1'b1, 32'd100, 4'hF, 1'b1, SUM_WORD, 1'b0, 1'b0);
        checkRecord("bp_hold2", 32'd7, 32'd1, 1'b0, 32'd6);
        s_valid = 1'b1; s_data = 32'd9; s_keep = 4'hF; s_last = 1'b1; m_ready = 1'b1;
        #1;
        checkOutput("bp_ready_comb", 80'(s_ready), 80'(1'b1));
        applyStimulus(1'b1, 32'd9, 4'hF, 1'b1, SUM_WORD, 1'b1, 1'b0);
        checkRecord("bp_b", 32'd9, 32'd1, 1'b0, 32'd7);

        // Zero-keep last beat still closes a frame.
        applyStimulus(1'b1, 32'hDEADBEEF, 4'h0, 1'b1, SUM_WORD, 1'b1, 1'b0);
        checkRecord("zero_keep", 32'd0, 32'd0, 1'b0, 32'd8);

        // Mid-frame clear with a beat offered in the clear cycle.
        applyStimulus(1'b1, 32'h4, 4'hF, 1'b0, SUM_WORD, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h4, 4'hF, 1'b0, SUM_WORD, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'd50, 4'hF, 1'b0, SUM_WORD, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h1, 4'hF, 1'b1, SUM_WORD, 1'b1, 1'b0);
        checkRecord("clear", 32'd1, 32'd1, 1'b0, 32'd9);

        // Pending record survives clear; a last beat accepted under clear makes no record.
        applyStimulus(1'b1, 32'h7, 4'hF, 1'b1, SUM_WORD, 1'b0, 1'b1);
        checkRecord("clear_pending", 32'd1, 32'd1, 1'b0, 32'd9);
        applyStimulus(1'b1, 32'h7, 4'hF, 1'b1, SUM_WORD, 1'b1, 1'b1);
        checkOutput("clear_drop_valid", 80'(m_valid), 80'(1'b0));
        checkOutput("clear_drop_frames", 80'(frame_cnt), 80'(32'd9));

        // Reset with a pending record and an offered beat.
        applyStimulus(1'b1, 32'h3, 4'hF, 1'b0, SUM_WORD, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'd10, 4'hF, 1'b1, SUM_WORD, 1'b0, 1'b0);
        checkRecord("pre_reset", 32'd13, 32'd2, 1'b0, 32'd10);
        reset = 1'b1;
        applyStimulus(1'b1, 32'd20, 4'hF, 1'b0, SUM_WORD, 1'b0, 1'b0);
        reset = 1'b0;
        checkOutput("rst2_valid", 80'(m_valid), 80'(1'b0));
        checkOutput("rst2_ready", 80'(s_ready), 80'(1'b1));
        checkOutput("rst2_frames", 80'(frame_cnt), 80'(0));

        // Partial frame dropped by reset; next frame starts from zero.
        applyStimulus(1'b1, 32'd20, 4'hF, 1'b0, SUM_WORD, 1'b1, 1'b0);
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, SUM_WORD, 1'b1, 1'b0);
        reset = 1'b0;
        applyStimulus(1'b1, 32'h5, 4'hF, 1'b1, SUM_WORD, 1'b1, 1'b0);
        checkRecord("post_reset", 32'd5, 32'd1, 1'b0, 32'd1);

        applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, SUM_WORD, 1'b1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_frame_sum.md
# axis_frame_sum

Parametrised AXI-Stream frame accumulator, the frame-aware successor to the fixed 32-bit stream-sum core. It sums byte-masked beats of a TLAST-delimited stream, with a runtime-selectable word or byte-lane mode, and emits one result record per frame on a registered valid/ready output. It sits between a DMA read stream and the accelerator's status/result path, and exposes an ID constant and a frame counter for host polling.

## Interface
- DATA_W, 32: input data width; a multiple of 8, range 8..512; KEEP_W = DATA_W/8.
- SUM_W, 32: accumulator width; must be >= DATA_W.
- CNT_W, 32: beat-count and frame-count width.
- ACCEL_ID, 32'hdeadbeef: constant driven on accel_id.
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- clear  in  1  synchronous; aborts the partial frame.
- sum_mode  in  1  0 = word mode, 1 = byte-lane mode; sampled on every beat.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat ready.
- s_data  in  DATA_W  beat data.
- s_keep  in  KEEP_W  byte enables.
- s_last  in  1  last beat of the frame.
- m_valid  out  1  result record valid.
- m_ready  in  1  result record accepted.
- m_sum  out  SUM_W  frame sum.
- m_cnt  out  CNT_W  counted beats in the frame.
- m_ovf  out  1  the frame sum wrapped.
- frame_cnt  out  CNT_W  frames emitted, wraps at 2^CNT_W.
- accel_id  out  32  equals ACCEL_ID.

## Operation
- A beat is accepted when s_valid and s_ready are both high.
- Masked word: byte i of s_data is used if s_keep[i] is 1, otherwise it is zero.
- Beat term in word mode: the masked word, zero-extended to SUM_W.
- Beat term in byte-lane mode: the sum of all masked bytes, zero-extended to SUM_W.
- Accumulator acc: acc <= acc + term, modulo 2^SUM_W. A carry out of bit SUM_W-1 sets the sticky flag ovf.
- cnt increments only on beats with s_keep != 0. Beats with all-zero keep are accepted but add nothing; their s_last still closes the frame. cnt wraps modulo 2^CNT_W.
- On an accepted beat with s_last high:
  - the result register loads the final values, including this beat: {acc+term, cnt', ovf'};
  - m_valid goes high;
  - acc, cnt and ovf clear to 0 on the same edge;
  - frame_cnt increments.
- s_ready = !m_valid | m_ready. This forms a one-entry result buffer; a pending unaccepted result stalls input at every beat, not only at last beats.
- clear: acc, cnt and ovf go to 0, and a beat accepted in the same cycle is discarded. A pending result, m_valid and frame_cnt are unaffected.
- Reset values:
  - all outputs are 0 except s_ready = 1 and accel_id = ACCEL_ID;
  - acc, cnt and ovf are 0;
  - reset mid-frame drops the partial frame and any pending result.

## Timing
- Latency: m_valid rises on the edge that accepts the last beat. The record is visible in the following cycle.
- Throughput: one beat per cycle while m_ready is held high. Back-to-back single-beat frames sustain 1 frame/cycle.
- Simultaneous m_ready and a new last beat: the old record retires and the new record loads on the same edge; m_valid stays high.
- While m_valid=1 and m_ready=0: s_ready=0, and m_sum/m_cnt/m_ovf are held stable.
- frame_cnt updates on the same edge as m_valid's load, not on acceptance.
- Synchronous-reset priority: reset over clear, and clear over beat accumulation.

## Structure
- Package axis_sum_pkg holds:
  - the mode enum (SUM_WORD=0, SUM_BYTE=1);
  - the default parameter constants;
  - a packed result-record struct {sum, cnt, ovf} parameterised through localparams.
- Sub-module axis_keep_lane_sum, purely combinational: masks s_data with s_keep and returns the term for the selected mode. The adder tree in byte-lane mode has width DATA_W/8-summing, i.e. 8+clog2(KEEP_W) bits.
- The top level holds the accumulator, the counters and the result register/handshake.

## Test plan
- DATA_W=32, word mode: beats 0x00000001, 0x00000002 and 0x00000003 (last), keep=0xF, m_ready=1 → one record {sum=6, cnt=3, ovf=0}; frame_cnt=1.
- Keep masking: beat 0xAABBCCDD, keep=0x5, last → word mode gives sum=0x00BB00DD; byte mode gives sum=0xBB+0xDD=0x198; cnt=1 in both.
- Overflow with SUM_W=32: beats 0xFFFFFFFF and 0x00000002 (last) → sum=1, ovf=1. The next frame of 0x5 (last) gives {5, 1, ovf=0}.
- Backpressure:
  - hold m_ready=0 after frame A={7} completes;
  - s_ready must be 0 and m_sum must stay at 7 throughout;
  - assert m_ready on the same cycle that frame B's single last beat {9} is offered;
  - required: A retires, B loads, and m_valid stays high.
- Zero-keep and clear:
  - keep=0 last beat → record {0, 0, 0};
  - mid-frame clear after beats {4, 4}, then beat 1 (last) → record {1, 1, 0};
  - a pending result survives the clear.
- Reset mid-frame with m_valid=1 → next cycle m_valid=0, s_ready=1, frame_cnt=0; the next frame's sum starts from 0.
